// File: rtl/qu_common.sv
// Shared types and constants for the qu core memory subsystem.
// Holds the response-tag encoding and default starvation limit used by qu_mem_arbiter.
package qu_common;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_IF   = 2'd1,
        TAG_LS   = 2'd2
    } mem_arb_tag_t;

    localparam int QU_MEM_ARB_STARVE_LIMIT = 4;

endpackage

// File: rtl/qu_mem_arbiter.sv
// Shares one single-port, 1-cycle-latency RAM between instruction fetch and load/store.
// Optional fetch starvation guard is enabled by defining QU_MEM_ARB_STARVE_GUARD_EN.
module qu_mem_arbiter
    import qu_common::*;
#(
    parameter int ADDR_WIDTH   = 10,
    parameter int DATA_WIDTH   = 32
`ifdef QU_MEM_ARB_STARVE_GUARD_EN
    ,
    parameter int STARVE_LIMIT = QU_MEM_ARB_STARVE_LIMIT
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req_valid,
    output logic                  if_req_ready,
    input  logic [ADDR_WIDTH-1:0] if_req_addr,
    input  logic                  if_flush,
    output logic                  if_rsp_valid,
    output logic [DATA_WIDTH-1:0] if_rsp_data,
    input  logic                  ls_req_valid,
    output logic                  ls_req_ready,
    input  logic                  ls_req_we,
    input  logic [ADDR_WIDTH-1:0] ls_req_addr,
    input  logic [DATA_WIDTH-1:0] ls_req_wdata,
    output logic                  ls_rsp_valid,
    output logic [DATA_WIDTH-1:0] ls_rsp_data,
    input  logic                  mem_ready,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    logic         if_grant;
    logic         ls_grant;
    logic         force_if;
    logic         flush_pend_q;
    mem_arb_tag_t tag_q;
    mem_arb_tag_t tag_d;

    // Winner selection; the rst term keeps every grant low while reset is held.
    always_comb begin
        if_grant = 1'b0;
        ls_grant = 1'b0;
        if (rst && mem_ready) begin
            if (if_req_valid && (force_if || !ls_req_valid)) begin
                if_grant = 1'b1;
            end else if (ls_req_valid) begin
                ls_grant = 1'b1;
            end
        end
    end

    always_comb begin
        tag_d = TAG_NONE;
        if (if_grant) begin
            tag_d = TAG_IF;
        end else if (ls_grant && !ls_req_we) begin
            tag_d = TAG_LS;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_q        <= TAG_NONE;
            flush_pend_q <= 1'b0;
        end else begin
            tag_q        <= tag_d;
            flush_pend_q <= if_flush && if_grant;
        end
    end

`ifdef QU_MEM_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_cnt_q;

    assign force_if = (starve_cnt_q == CNT_W'(STARVE_LIMIT));

    // Counts denied fetch cycles in which memory could have served it; saturates at the limit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt_q <= '0;
        end else if (!if_req_valid || if_grant) begin
            starve_cnt_q <= '0;
        end else if (mem_ready && !force_if) begin
            starve_cnt_q <= starve_cnt_q + CNT_W'(1);
        end
    end
`else
    assign force_if = 1'b0;
`endif

    assign if_req_ready = if_grant;
    assign ls_req_ready = ls_grant;

    assign mem_en    = if_grant || ls_grant;
    assign mem_we    = ls_grant && ls_req_we;
    assign mem_addr  = ls_grant ? ls_req_addr : if_req_addr;
    assign mem_wdata = ls_req_wdata;

    // A flush kills both the response landing now and one from a fetch granted alongside it.
    assign if_rsp_valid = (tag_q == TAG_IF) && !flush_pend_q && !if_flush;
    assign if_rsp_data  = mem_rdata;
    assign ls_rsp_valid = (tag_q == TAG_LS);
    assign ls_rsp_data  = mem_rdata;

endmodule
